// File: rtl/multicycle_control_if.sv
// Unified-memory handshake between the multicycle control FSM and memory.
// Ports: mem_read/mem_write/i_or_d (request side), mem_ready (completion).
interface multicycle_control_if;
    logic mem_read;
    logic mem_write;
    logic i_or_d;
    logic mem_ready;

    modport master (
        output mem_read,
        output mem_write,
        output i_or_d,
        input  mem_ready
    );

    modport slave (
        input  mem_read,
        input  mem_write,
        input  i_or_d,
        output mem_ready
    );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM (R-type, ADDI, LW, SW, BEQ, J) for a
// shared-ALU/shared-memory datapath with a variable-latency memory.
// Ports: clk, rst (sync, active high), opcode (IR[31:26]), mem (handshake
// interface), datapath controls, illegal/mem_err pulses, state (debug).
// Optional MULTICYCLE_PERF_CNT_EN adds cycle_cnt and instr_cnt outputs.
module multicycle_control #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [5:0]           opcode,
    multicycle_control_if.master mem,
    output logic                 pc_write,
    output logic                 pc_write_cond,
    output logic                 ir_write,
    output logic                 reg_dst,
    output logic                 mem_2_reg,
    output logic                 reg_write,
    output logic                 alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [1:0]           alu_op,
    output logic [1:0]           pc_source,
    output logic                 illegal,
    output logic                 mem_err,
    output logic [3:0]           state
`ifdef MULTICYCLE_PERF_CNT_EN
    ,
    output logic [31:0]          cycle_cnt,
    output logic [31:0]          instr_cnt
`endif
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXECUTE   = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EX   = 4'd10,
        S_ADDI_WB   = 4'd11
    } state_e;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_J    = 6'h02;

    state_e     state_q, state_d;
    logic [7:0] wcnt_q, wcnt_d;
    logic       in_mem;
    logic       timeout;
    logic       ready;

    assign in_mem  = (state_q == S_FETCH) || (state_q == S_MEM_READ) ||
                     (state_q == S_MEM_WRITE);
    // Once the wait budget is spent the request is dropped, so a late
    // mem_ready in that same cycle must not complete the access.
    assign timeout = in_mem && (wcnt_q >= 8'(MEM_TIMEOUT));
    assign ready   = in_mem && !timeout && mem.mem_ready;

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:     state_d = ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_R:         state_d = S_EXECUTE;
                    OP_ADDI:      state_d = S_ADDI_EX;
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEM_ADDR:  state_d = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:  state_d = timeout ? S_FETCH :
                                   ready ? S_MEM_WB : S_MEM_READ;
            S_MEM_WRITE: state_d = (timeout || ready) ? S_FETCH : S_MEM_WRITE;
            S_EXECUTE:   state_d = S_R_WB;
            S_ADDI_EX:   state_d = S_ADDI_WB;
            default:     state_d = S_FETCH;
        endcase
    end

    // Counter only survives while a memory state waits on itself; any
    // entry (including a FETCH retry after timeout) starts from zero.
    assign wcnt_d = (in_mem && !timeout && !ready) ? wcnt_q + 8'd1 : 8'd0;

`ifdef MULTICYCLE_PERF_CNT_EN
    logic retire;
    logic [31:0] cyc_q, ins_q;

    assign retire = (state_q == S_MEM_WB) || (state_q == S_R_WB) ||
                    (state_q == S_ADDI_WB) || (state_q == S_BRANCH) ||
                    (state_q == S_JUMP) ||
                    ((state_q == S_MEM_WRITE) && ready);
    assign cycle_cnt = rst ? 32'd0 : cyc_q;
    assign instr_cnt = rst ? 32'd0 : ins_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            wcnt_q  <= 8'd0;
`ifdef MULTICYCLE_PERF_CNT_EN
            cyc_q   <= 32'd0;
            ins_q   <= 32'd0;
`endif
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
`ifdef MULTICYCLE_PERF_CNT_EN
            cyc_q   <= cyc_q + 32'd1;
            if (retire)
                ins_q <= ins_q + 32'd1;
`endif
        end
    end

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        mem.i_or_d    = 1'b0;
        mem.mem_read  = 1'b0;
        mem.mem_write = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        mem_2_reg     = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
        illegal       = 1'b0;
        mem_err       = 1'b0;
        state         = rst ? 4'd0 : state_q;
        if (!rst) begin
            if (timeout) begin
                mem_err = 1'b1;
            end else begin
                case (state_q)
                    S_FETCH: begin
                        mem.mem_read = 1'b1;
                        alu_src_b    = 2'b01;
                        ir_write     = mem.mem_ready;
                        pc_write     = mem.mem_ready;
                    end
                    S_DECODE: begin
                        alu_src_b = 2'b11;
                        illegal   = (state_d == S_FETCH);
                    end
                    S_MEM_ADDR: begin
                        alu_src_a = 1'b1;
                        alu_src_b = 2'b10;
                    end
                    S_MEM_READ: begin
                        mem.mem_read = 1'b1;
                        mem.i_or_d   = 1'b1;
                    end
                    S_MEM_WB: begin
                        reg_write = 1'b1;
                        mem_2_reg = 1'b1;
                    end
                    S_MEM_WRITE: begin
                        mem.mem_write = 1'b1;
                        mem.i_or_d    = 1'b1;
                    end
                    S_EXECUTE: begin
                        alu_src_a = 1'b1;
                        alu_op    = 2'b10;
                    end
                    S_R_WB: begin
                        reg_write = 1'b1;
                        reg_dst   = 1'b1;
                    end
                    S_BRANCH: begin
                        alu_src_a     = 1'b1;
                        alu_op        = 2'b01;
                        pc_write_cond = 1'b1;
                        pc_source     = 2'b01;
                    end
                    S_JUMP: begin
                        pc_write  = 1'b1;
                        pc_source = 2'b10;
                    end
                    S_ADDI_EX: begin
                        alu_src_a = 1'b1;
                        alu_src_b = 2'b10;
                    end
                    S_ADDI_WB: reg_write = 1'b1;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multicycle MIPS control FSM. Sequences the shared-ALU/shared-memory datapath through fetch, decode, execute, memory and write-back steps for R-type, ADDI, LW, SW, BEQ and J. It sits beside the datapath registers (PC, IR, MDR, A/B, ALUOut) and handshakes with a variable-latency unified memory. The datapath ALU control decodes `alu_op` with the existing encoding: 00 add, 01 sub, 10 R-type funct.

## Interface
- `MEM_TIMEOUT`, 16: maximum wait cycles for `mem_ready` in any memory state before abort; range 1–255.
- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous reset, active high.
- `opcode` in 6: IR[31:26]; valid from DECODE onward.
- `mem_ready` in 1: memory completed the current read or write this cycle.
- `pc_write` out 1: unconditional PC load.
- `pc_write_cond` out 1: PC load if ALU zero.
- `i_or_d` out 1: memory address select; 0 is PC, 1 is ALUOut.
- `mem_read` / `mem_write` out 1 each: memory request, held until `mem_ready`.
- `ir_write` out 1: IR load.
- `reg_dst` out 1: write-register select; 1 is rd.
- `mem_2_reg` out 1: write-back source; 1 is MDR.
- `reg_write` out 1: register file write.
- `alu_src_a` out 1: 0 is PC, 1 is A.
- `alu_src_b` out 2: 00 is B, 01 is constant 4, 10 is sign-extended imm, 11 is imm<<2.
- `alu_op` out 2: ALU operation class.
- `pc_source` out 2: 00 is ALU result, 01 is ALUOut, 10 is jump target.
- `illegal` out 1: one-cycle pulse when an unsupported opcode is decoded.
- `mem_err` out 1: one-cycle pulse on a memory timeout.
- `state` out 4: current state, for debug.

## Operation
- State encodings:
  - FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5.
  - EXECUTE=6, R_WB=7, BRANCH=8, JUMP=9, ADDI_EX=10, ADDI_WB=11.
- Any output not listed for a state is 0.
- FETCH: `mem_read`=1, `i_or_d`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=00, `pc_source`=00.
  - `ir_write` and `pc_write` = `mem_ready`; these are the only Mealy outputs.
  - Stays in FETCH until `mem_ready`, then goes to DECODE.
- DECODE: `alu_src_a`=0, `alu_src_b`=11, `alu_op`=00. Dispatch on opcode:
  - 0x00 → EXECUTE; 0x08 → ADDI_EX; 0x23 or 0x2B → MEM_ADDR; 0x04 → BRANCH; 0x02 → JUMP.
  - Any other opcode: pulse `illegal`, go to FETCH.
- MEM_ADDR: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00. Opcode 0x23 → MEM_READ, otherwise → MEM_WRITE.
- MEM_READ: `mem_read`=1, `i_or_d`=1; on `mem_ready` → MEM_WB.
- MEM_WB: `reg_write`=1, `mem_2_reg`=1, `reg_dst`=0; → FETCH.
- MEM_WRITE: `mem_write`=1, `i_or_d`=1; on `mem_ready` → FETCH.
- EXECUTE: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=10; → R_WB.
- R_WB: `reg_write`=1, `reg_dst`=1; → FETCH.
- ADDI_EX: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00; → ADDI_WB.
- ADDI_WB: `reg_write`=1, `reg_dst`=0; → FETCH.
- BRANCH: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=01, `pc_write_cond`=1, `pc_source`=01; → FETCH.
- JUMP: `pc_write`=1, `pc_source`=10; → FETCH.
- Wait counter:
  - Cleared on entry to FETCH, MEM_READ and MEM_WRITE; increments each cycle without `mem_ready`.
  - If it reaches `MEM_TIMEOUT` before `mem_ready`, the FSM drops the request, pulses `mem_err` for one cycle and goes to FETCH.
  - In FETCH the PC is not advanced and the fetch is retried.
- `mem_ready` outside FETCH, MEM_READ and MEM_WRITE is ignored.
- Unused state encodings 12–15 go to FETCH on the next edge with all outputs 0.

## Timing
- Reset:
  - `rst`=1 at an edge sets `state`=FETCH and clears the wait counter.
  - While `rst` is high, every output is forced to 0, including `mem_read`, `illegal` and `mem_err`.
  - Reset mid-instruction abandons it; no `reg_write` or `pc_write` is issued.
- Cycles per instruction with zero-wait memory (`mem_ready` high in the first request cycle):
  - R-type, ADDI: 4.
  - LW: 5.
  - SW: 4.
  - BEQ, J: 3.
  - Each memory wait cycle adds 1.
- Requests (`mem_read`, `mem_write`) are held stable from the first request cycle through the `mem_ready` cycle inclusive. They deassert the cycle after `mem_ready`.
- `opcode` is sampled only in DECODE and MEM_ADDR.

## Configuration
- `MULTICYCLE_PERF_CNT_EN` defined:
  - Adds outputs `cycle_cnt` out 32 and `instr_cnt` out 32, both reset to 0.
  - `cycle_cnt` increments every non-reset cycle.
  - `instr_cnt` increments on each transition into FETCH from MEM_WB, MEM_WRITE (after `mem_ready`), R_WB, ADDI_WB, BRANCH or JUMP. Illegal opcodes and timeouts do not count.
  - Both counters wrap 0xFFFFFFFF → 0.
- Macro not defined: these ports and counters are absent; behaviour is otherwise identical.

## Test plan
- Reset: `rst` high 3 cycles with `mem_ready`=1 → all outputs 0. First cycle after release: `state`=0, `mem_read`=1, `ir_write`=1, `pc_write`=1.
- R-type (opcode 0x00), zero-wait → states 0,1,6,7. `alu_op`=10 in EXECUTE; `reg_write`=1 and `reg_dst`=1 in R_WB. Back in FETCH 4 cycles after the first fetch.
- LW (0x23) with 2 wait cycles on both fetch and data → states 0,0,0,1,2,3,3,3,4, for 9 cycles. `i_or_d`=1 throughout MEM_READ; `mem_2_reg`=1 in MEM_WB.
- BEQ (0x04), then J (0x02) → `pc_write_cond`=1 with `pc_source`=01 for exactly 1 cycle, then `pc_write`=1 with `pc_source`=10 for exactly 1 cycle. 3 cycles each.
- Illegal opcode 0x3F → `illegal` high one cycle in DECODE, next state FETCH, no `reg_write`.
- `mem_ready` held low in MEM_WRITE with `MEM_TIMEOUT`=16 → `mem_write` high 16 cycles, then `mem_err` pulses once and FSM goes to FETCH. With the perf macro defined, `instr_cnt` is unchanged.
